// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver that validates the start bit at mid-bit and samples at bit centres.
// Default frame is 8N1; define UART_RX_PARITY_EN for an 11-bit frame with an even-parity bit.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic sync_q;
  logic rx_s;
  logic rx_s_d;

  // Resetting to 0 means a frame can only start after the line has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      rx_s   <= 1'b0;
      rx_s_d <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's old value.
      sync_q <= rx_in;
      rx_s   <= sync_q;
      rx_s_d <= rx_s;
    end
  end

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        bit_end;
`ifdef UART_RX_PARITY_EN
  logic        parity_bit;
`endif

  assign bit_end = (timer == FULL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      timer      <= timer + 16'd1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_s_d && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            timer   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            timer      <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= (^shift) ^ parity_bit;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives serial frames and compares the strobes against a frame-level model.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_core;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_data = 8'h00;
  logic [10:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every strobe cycle is logged as {valid, frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || parity_err))
      got_q.push_back({rx_valid, frame_err, parity_err, rx_data});
  end

  // Frame-level model: good stop delivers the byte, bad stop keeps the held byte.
  function automatic logic [10:0] model(input logic [7:0] d, input logic stop_b,
                                        input logic par_b, input logic [7:0] held);
    if (stop_b) return {1'b1, 1'b0, PAR ? ((^d) ^ par_b) : 1'b0, d};
    return {1'b0, 1'b1, 1'b0, held};
  endfunction

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d,
                              input logic stop_b, input logic par_b);
    logic [10:0] exp;
    exp = model(d, stop_b, par_b, exp_data);
    if (got_q.size() == 0) check({tag, "_missing"}, 32'd0, 32'd1);
    else check(tag, 32'(got_q.pop_front()), 32'(exp));
    if (stop_b) exp_data = d;
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_check(input string tag, input logic [7:0] d,
                            input logic stop_b, input logic par_b);
    send_frame(d, stop_b, par_b);
    expect_frame(tag, d, stop_b, par_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    int         rise;
    int         fall;

    rx_in = 1'b1;
    rst   = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_strobes", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (100) @(posedge clk);
    #2;

    send_check("a5", 8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1);

    // Back-to-back frames with single stop bits.
    send_check("b2b_00", 8'h00, 1'b1, 1'b0);
    send_check("b2b_ff", 8'hFF, 1'b1, 1'b0);
    send_check("b2b_3c", 8'h3C, 1'b1, 1'b0);
    drive_bit(1'b1);

    // Short low glitch on the idle line must be rejected at mid-bit.
    rx_in = 1'b0;
    repeat (6) @(posedge clk);
    #2 rx_in = 1'b1;
    rise = -1;
    fall = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && rise < 0) rise = i;
      if (!busy && rise >= 0 && fall < 0) fall = i;
    end
    check("glitch_busy_seen", 32'(rise >= 0), 32'd1);
    check("glitch_busy_clear", 32'(fall >= 0 && fall <= 8), 32'd1);
    check("glitch_no_strobe", 32'(got_q.size()), 32'd0);
    #2;
    send_check("after_glitch_5a", 8'h5A, 1'b1, 1'b0);
    drive_bit(1'b1);

    // Bad stop bit followed by a long break.
    send_check("break_81", 8'h81, 1'b0, 1'b0);
    repeat (50 * CPB) @(posedge clk);
    #2;
    check("break_no_strobe", 32'(got_q.size()), 32'd0);
    check("break_busy", 32'(busy), 32'd0);
    check("break_data_held", 32'(rx_data), 32'(exp_data));
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_check("after_break_42", 8'h42, 1'b1, 1'b0);
    drive_bit(1'b1);

    // Reset in the middle of data bit 4 of 0xC3.
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (CPB / 2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    rx_in = 1'b1;
    exp_data = 8'h00;
    repeat (2 * CPB) @(posedge clk);
    #2;
    check("midrst_no_strobe", 32'(got_q.size()), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(rx_data), 32'h00);
    send_check("after_rst_11", 8'h11, 1'b1, 1'b0);
    drive_bit(1'b1);

    if (PAR) begin
      send_check("par_07_good", 8'h07, 1'b1, 1'b1);
      drive_bit(1'b1);
      send_check("par_07_bad", 8'h07, 1'b1, 1'b0);
      drive_bit(1'b1);
      send_check("par_bad_stop", 8'h07, 1'b0, 1'b0);
      drive_bit(1'b1);
    end

    // Random frames: occasional bad stop bits, occasional wrong parity, random gaps.
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
      send_check("rand", d, stop_b, par_b);
      if (stop_b) repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      else repeat ($urandom_range(1, 2)) drive_bit(1'b1);
    end

    repeat (2 * CPB) @(posedge clk);
    check("leftover_strobes", 32'(got_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
